// File: rtl/flash_sample_reader.sv
// Sample-word reader: one Avalon-MM pipelined flash read per request,
// owning the two-samples-per-word pointer with forward/backward wrap.
module flash_sample_reader #(
    parameter int unsigned ADDR_W = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR = 23'h07FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_start,
    input  logic              back_mode,
    input  logic              restart,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic              flash_mem_read,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [31:0]       data_out,
    output logic              read_finish,
    output logic              is_first,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_VALID,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] word_addr;
    logic              restart_pending;
    logic [ADDR_W-1:0] restart_addr;
    logic [ADDR_W-1:0] step_addr;

    assign flash_mem_address    = word_addr;
    assign flash_mem_byteenable = 4'b1111;

    // Restart lands on whichever end the current direction starts from.
    always_comb begin
        restart_addr = back_mode ? END_ADDR : START_ADDR;
        step_addr    = word_addr;
        if (back_mode) begin
            step_addr = (word_addr == START_ADDR) ? END_ADDR
                                                  : word_addr - ONE;
        end else begin
            step_addr = (word_addr == END_ADDR) ? START_ADDR
                                                : word_addr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            word_addr       <= START_ADDR;
            is_first        <= 1'b1;
            restart_pending <= 1'b0;
            data_out        <= '0;
            read_finish     <= 1'b0;
            flash_mem_read  <= 1'b0;
            busy            <= 1'b0;
        end else begin
            read_finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (restart) begin
                        word_addr <= restart_addr;
                        is_first  <= 1'b1;
                    end
                    if (read_start) begin
                        state          <= ISSUE;
                        flash_mem_read <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (restart) restart_pending <= 1'b1;
                    if (!flash_mem_waitrequest) begin
                        state          <= WAIT_VALID;
                        flash_mem_read <= 1'b0;
                    end
                end
                WAIT_VALID: begin
                    if (restart) restart_pending <= 1'b1;
                    if (flash_mem_readdatavalid) begin
                        data_out    <= flash_mem_readdata;
                        read_finish <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    // Phase flips every word; address moves only after the second half.
                    if (restart_pending || restart) begin
                        word_addr       <= restart_addr;
                        is_first        <= 1'b1;
                        restart_pending <= 1'b0;
                    end else if (is_first) begin
                        is_first <= 1'b0;
                    end else begin
                        is_first  <= 1'b1;
                        word_addr <= step_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader with a small song window
// (START_ADDR=0, END_ADDR=3) so both wrap points are reachable.
module tb_flash_sample_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_start = 1'b0;
    logic        back_mode = 1'b0;
    logic        restart = 1'b0;
    logic [22:0] flash_mem_address;
    logic        flash_mem_read;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = '0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic [31:0] data_out;
    logic        read_finish;
    logic        is_first;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [22:0] a;
    int          strobes, fin, fk;
    logic        stable, isf_fin, isf_after;
    logic [31:0] dout;

    always #5 clk = ~clk;

    flash_sample_reader #(
        .ADDR_W(23),
        .START_ADDR(23'h000000),
        .END_ADDR(23'h000003)
    ) dut (
        .clk(clk),
        .reset(reset),
        .read_start(read_start),
        .back_mode(back_mode),
        .restart(restart),
        .flash_mem_address(flash_mem_address),
        .flash_mem_read(flash_mem_read),
        .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdata(flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .data_out(data_out),
        .read_finish(read_finish),
        .is_first(is_first),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse read_start, then act as the flash slave: ws stall cycles,
    // data valid vd cycles after acceptance. Cycle 1 follows the request.
    task automatic req(input int ws, input int vd, input logic [31:0] dat,
                       input int rs_k, input int st_k,
                       output logic [22:0] addr, output int nstr,
                       output int nfin, output int fin_k,
                       output logic stab, output logic f_fin,
                       output logic f_after, output logic [31:0] d);
        int acc;
        acc = 0; nstr = 0; nfin = 0; fin_k = 0; stab = 1'b1;
        addr = '0; f_fin = 1'b0; f_after = 1'b0; d = '0;
        @(negedge clk);
        read_start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            read_start = (k == st_k);
            restart = (k == rs_k);
            if (flash_mem_read) begin
                if (nstr == 0) addr = flash_mem_address;
                else if (flash_mem_address !== addr) stab = 1'b0;
                nstr++;
            end
            flash_mem_waitrequest = flash_mem_read && (nstr <= ws);
            if (flash_mem_read && !flash_mem_waitrequest) acc = k;
            flash_mem_readdatavalid = (acc > 0) && (k == acc + vd);
            flash_mem_readdata = flash_mem_readdatavalid ? dat : $urandom;
            if (read_finish) begin
                nfin++;
                if (fin_k == 0) begin
                    fin_k = k;
                    f_fin = is_first;
                    d = data_out;
                end
            end
            if (fin_k != 0 && k == fin_k + 1) begin
                f_after = is_first;
                break;
            end
        end
        read_start = 1'b0;
        restart = 1'b0;
        flash_mem_waitrequest = 1'b0;
        flash_mem_readdatavalid = 1'b0;
    endtask

    initial begin
        logic [22:0] exp_a [4];
        logic        exp_f [4];
        exp_a = '{23'd0, 23'd0, 23'd1, 23'd1};
        exp_f = '{1'b0, 1'b1, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(flash_mem_read), 32'd0);
        chk("rst_finish", 32'(read_finish), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_is_first", 32'(is_first), 32'd1);
        chk("rst_addr", 32'(flash_mem_address), 32'd0);
        chk("byteenable", 32'(flash_mem_byteenable), 32'hF);

        req(0, 1, 32'hA1B2C3D4, 0, 0, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        chk("t1_addr", 32'(a), 32'd0);
        chk("t1_strobes", strobes, 1);
        chk("t1_finish_cycle", fk, 3);
        chk("t1_pulses", fin, 1);
        chk("t1_data", dout, 32'hA1B2C3D4);
        chk("t1_is_first", 32'(isf_fin), 32'd1);
        chk("t1_phase_after", 32'(isf_after), 32'd0);

        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("idle_rst_read", 32'(flash_mem_read), 32'd0);
        chk("idle_rst_busy", 32'(busy), 32'd0);
        chk("idle_rst_first", 32'(is_first), 32'd1);
        chk("idle_rst_addr", 32'(flash_mem_address), 32'd0);

        for (int i = 0; i < 4; i++) begin
            req(0, 1, 32'h1000_0000 + 32'(i), 0, 0, a, strobes, fin, fk,
                stable, isf_fin, isf_after, dout);
            chk($sformatf("b2b%0d_addr", i), 32'(a), 32'(exp_a[i]));
            chk($sformatf("b2b%0d_first", i), 32'(isf_after),
                32'(exp_f[i]));
            chk($sformatf("b2b%0d_strobes", i), strobes, 1);
            chk($sformatf("b2b%0d_data", i), dout,
                32'h1000_0000 + 32'(i));
        end

        req(3, 2, 32'h5A5A_0F0F, 0, 0, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        chk("ws_addr", 32'(a), 32'd2);
        chk("ws_strobes", strobes, 4);
        chk("ws_stable", 32'(stable), 32'd1);
        chk("ws_finish_cycle", fk, 7);
        chk("ws_pulses", fin, 1);
        chk("ws_data", dout, 32'h5A5A_0F0F);

        req(0, 1, 32'h1, 0, 0, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        chk("fw_a2", 32'(a), 32'd2);
        chk("fw_a2_next", 32'(flash_mem_address), 32'd3);
        req(0, 1, 32'h2, 0, 0, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        req(0, 1, 32'h3, 0, 0, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        chk("fw_end_addr", 32'(a), 32'd3);
        chk("fw_wrap_addr", 32'(flash_mem_address), 32'd0);
        chk("fw_wrap_first", 32'(is_first), 32'd1);

        back_mode = 1'b1;
        req(0, 1, 32'h4, 0, 0, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        chk("bk_addr", 32'(a), 32'd0);
        chk("bk_hold", 32'(flash_mem_address), 32'd0);
        chk("bk_phase", 32'(isf_after), 32'd0);
        req(0, 1, 32'h5, 0, 0, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        chk("bk_wrap_addr", 32'(flash_mem_address), 32'd3);
        chk("bk_wrap_first", 32'(is_first), 32'd1);
        back_mode = 1'b0;

        req(0, 3, 32'hCAFE_F00D, 2, 3, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        chk("rp_addr", 32'(a), 32'd3);
        chk("rp_data", dout, 32'hCAFE_F00D);
        chk("rp_strobes", strobes, 1);
        chk("rp_finish_cycle", fk, 5);
        chk("rp_pulses", fin, 1);
        chk("rp_next_addr", 32'(flash_mem_address), 32'd0);
        chk("rp_next_first", 32'(isf_after), 32'd1);
        req(0, 1, 32'h6, 0, 0, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        chk("rp_read_addr", 32'(a), 32'd0);
        chk("rp_read_first", 32'(isf_fin), 32'd1);

        @(negedge clk);
        read_start = 1'b1;
        flash_mem_waitrequest = 1'b1;
        @(negedge clk);
        read_start = 1'b0;
        chk("ar_issue_read", 32'(flash_mem_read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("ar_read", 32'(flash_mem_read), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ar_stale_finish", 32'(read_finish), 32'd0);
        flash_mem_readdatavalid = 1'b0;
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        chk("ar_stale_finish2", 32'(read_finish), 32'd0);
        chk("ar_stale_data", data_out, 32'd0);
        chk("ar_first", 32'(is_first), 32'd1);
        req(0, 1, 32'h7777_8888, 0, 0, a, strobes, fin, fk,
            stable, isf_fin, isf_after, dout);
        chk("ar_next_addr", 32'(a), 32'd0);
        chk("ar_next_data", dout, 32'h7777_8888);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
- Responder for the audio controller's sample-request handshake.
- Accepts a one-cycle read request and performs one Avalon-MM pipelined read of a 32-bit word from flash.
- Returns the word with a one-cycle finish pulse plus a sample-phase flag, which tells the controller which half-word sample to play.
- Owns the sample pointer:
  - two samples per word;
  - forward or backward traversal, selected by back_mode;
  - wrap-around at the song bounds.

Parameters:
- ADDR_W, 23, flash word-address width.
- START_ADDR, 23'h000000, first word of the song.
- END_ADDR, 23'h07FFFF, last word of the song (inclusive). END_ADDR >= START_ADDR.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- read_start  in  1  one-cycle request for the next sample word
- back_mode  in  1  0 = forward traversal, 1 = backward traversal
- restart  in  1  one-cycle pulse; return pointer to song start
- flash_mem_address  out  ADDR_W  Avalon word address
- flash_mem_read  out  1  Avalon read strobe
- flash_mem_byteenable  out  4  constant 4'b1111
- flash_mem_waitrequest  in  1  Avalon stall
- flash_mem_readdata  in  32  Avalon read data
- flash_mem_readdatavalid  in  1  Avalon data-valid
- data_out  out  32  captured word
- read_finish  out  1  one-cycle completion pulse
- is_first  out  1  1 = returned word serves the first sample of the pair
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state IDLE; word_addr = START_ADDR; phase = first.
  - data_out = 0; read_finish = 0; flash_mem_read = 0; busy = 0; is_first = 1.
  - restart_pending = 0.
- flash_mem_address always drives word_addr.
- is_first reflects phase. It changes only at the DONE update, so it is stable from one read_finish to the next.
- States:
  - IDLE:
    - read_start=1 -> ISSUE.
    - restart=1 in IDLE -> word_addr = START_ADDR (forward) or END_ADDR (back_mode=1), phase = first. No read is issued.
    - If read_start and restart are both 1, restart is applied first, then the read goes to the restarted address.
  - ISSUE:
    - flash_mem_read = 1, address held.
    - waitrequest=1 -> stay.
    - waitrequest=0 -> WAIT_VALID; flash_mem_read drops on the next cycle.
  - WAIT_VALID:
    - flash_mem_read = 0.
    - readdatavalid=1 -> data_out <= readdata, go to DONE.
    - readdatavalid asserted in any other state is ignored.
  - DONE (exactly one cycle):
    - read_finish = 1; go to IDLE.
    - Pointer update, evaluated with back_mode sampled this cycle:
      - restart_pending = 1 -> pointer restarted as in IDLE; pending cleared.
      - else phase = first -> phase becomes second; word_addr unchanged.
      - else phase = second -> phase becomes first, and word_addr moves:
        - forward: word_addr+1, with END_ADDR wrapping to START_ADDR;
        - backward: word_addr-1, with START_ADDR wrapping to END_ADDR.
- Handshake rules:
  - read_start while busy is ignored (not queued).
  - restart while busy sets restart_pending; the in-flight read completes normally.
- Latency: read_start at cycle N, with no stall and readdatavalid one cycle after acceptance:
  - flash_mem_read high in N+1;
  - data captured at the end of N+2;
  - read_finish high in N+3.
  - Each waitrequest or valid-delay cycle adds one cycle.
- Direction changes mid-pair take effect at the next word-advance decision only. The phase is never reset by a direction change.
- Reset mid-transaction: IDLE on the next edge with flash_mem_read = 0. A later readdatavalid from the aborted read is ignored.
- START_ADDR == END_ADDR: the address stays constant and only the phase toggles.

Test Plan:
- Reset, then read_start with waitrequest=0, and readdata=32'hA1B2C3D4 valid the cycle after acceptance -> read at address 0 in cycle 1, read_finish in cycle 3, data_out=32'hA1B2C3D4, is_first=1.
- Four back-to-back forward requests -> addresses 0,0,1,1; is_first after each finish 0,1,0,1; exactly one read strobe per request.
- waitrequest held for 3 cycles, readdatavalid delayed 2 cycles -> flash_mem_read high 4 cycles with address stable, read_finish 7 cycles after read_start, single pulse.
- Pointer at END_ADDR, phase second, forward request -> next address START_ADDR. Repeat at START_ADDR with back_mode=1 -> next address END_ADDR.
- restart pulsed while in WAIT_VALID, back_mode=0 -> current read completes with its data; next read at START_ADDR with is_first=1. read_start while busy produces no extra read.
- reset asserted during ISSUE with waitrequest=1 -> flash_mem_read=0 and busy=0 next cycle. A stale readdatavalid does not produce read_finish. The next read goes to START_ADDR.
